// File: rtl/reg_fetch.sv
// reg_fetch: operand-fetch stage between decode and execute.
// Holds the general register file, reads two source operands with
// write-through bypass from the writeback port, inserts one bubble on a
// read-after-write hazard against the instruction held for execute,
// honours execute back-pressure and squashes the wrong-path instruction
// on a taken branch.
module reg_fetch #(
  parameter int W_OPR  = 32,
  parameter int W_RD   = 5,
  parameter int ADDR   = 16,
  parameter int W_IMM  = 16,
  parameter int D_INFO = 16,
  parameter int W_CNT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  // decoded instruction from decode
  input  logic              v_i,
  input  logic [ADDR-1:0]   pc_i,
  input  logic [W_IMM-1:0]  imm_i,
  input  logic [W_RD-1:0]   rs0_i,
  input  logic [W_RD-1:0]   rs1_i,
  input  logic [W_RD-1:0]   rd_i,
  input  logic              use0_i,
  input  logic              use1_i,
  input  logic              wrsv_i,
  input  logic [D_INFO-1:0] d_info_i,
  output logic              stall_o,
  // instruction handed to execute
  output logic              v_o,
  output logic [ADDR-1:0]   pc_o,
  output logic [W_IMM-1:0]  imm_o,
  output logic [W_OPR-1:0]  opr0_o,
  output logic [W_OPR-1:0]  opr1_o,
  output logic [D_INFO-1:0] d_info_o,
  output logic [W_RD-1:0]   wb_r_o,
  output logic              wrsv_o,
  // feedback from execute
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic              wb_i,
  input  logic [W_RD-1:0]   wb_r_i,
  input  logic [W_OPR-1:0]  wb_data_i,
  // statistics
  output logic [W_CNT-1:0]  stall_cnt_o
);

  localparam int N_REG = 2 ** W_RD;

  logic [W_OPR-1:0] rf [N_REG];
  logic [W_OPR-1:0] src0;
  logic [W_OPR-1:0] src1;
  logic [W_OPR-1:0] opr0_n;
  logic [W_OPR-1:0] opr1_n;
  logic             hold;
  logic             hazard;
  logic             cnt_sat;

  // Operand read: writeback data bypasses the register file in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    src0   = rf[rs0_i];
    src1   = rf[rs1_i];
    opr0_n = {{(W_OPR-W_RD){1'b0}}, rs0_i};
    opr1_n = '0;
    if (wb_i && (wb_r_i == rs0_i)) src0 = wb_data_i;
    if (wb_i && (wb_r_i == rs1_i)) src1 = wb_data_i;
    // A non-register source 0 carries the branch condition code in its low bits.
    if (use0_i) opr0_n = src0;
    if (use1_i) opr1_n = src1;
  end

  // Hold when execute cannot accept; bubble when the held instruction will write
  // a register the incoming one reads. A taken branch discards the input instead.
  assign hold    = v_o & stall_i;
  assign hazard  = v_i & v_o & wrsv_o & ~branch_i &
                   ((use0_i & (rs0_i == wb_r_o)) | (use1_i & (rs1_i == wb_r_o)));
  assign stall_o = hold | hazard;
  assign cnt_sat = &stall_cnt_o;

  // Register file write from the execute writeback port.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the register file is cleared on reset because every register must read
    // zero afterwards; this keeps it in flops rather than a RAM macro.
    if (reset) begin
      for (int i = 0; i < N_REG; i++) rf[i] <= '0;
    end else if (wb_i) begin
      rf[wb_r_i] <= wb_data_i;
    end
  end

  // Output pipeline register and hazard-bubble counter; everything freezes on hold.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      v_o         <= 1'b0;
      pc_o        <= '0;
      imm_o       <= '0;
      opr0_o      <= '0;
      opr1_o      <= '0;
      d_info_o    <= '0;
      wb_r_o      <= '0;
      wrsv_o      <= 1'b0;
      stall_cnt_o <= '0;
    end else if (!hold) begin
      if (hazard && !cnt_sat) stall_cnt_o <= stall_cnt_o + W_CNT'(1);
      if (branch_i || hazard) begin
        // Squash or bubble: payload fields are don't-care and simply kept.
        v_o <= 1'b0;
      end else begin
        v_o      <= v_i;
        pc_o     <= pc_i;
        imm_o    <= imm_i;
        opr0_o   <= opr0_n;
        opr1_o   <= opr1_n;
        d_info_o <= d_info_i;
        wb_r_o   <= rd_i;
        wrsv_o   <= wrsv_i;
      end
    end
  end

endmodule

// File: tb/tb_reg_fetch.sv
// tb_reg_fetch: self-checking bench for reg_fetch. Directed scenarios plus a
// randomized phase compared against a cycle-level reference model built from
// the stage's rules (register array, plain expected-output variables).
module tb_reg_fetch;

  localparam int W_OPR   = 32;
  localparam int W_RD    = 5;
  localparam int ADDR    = 16;
  localparam int W_IMM   = 16;
  localparam int D_INFO  = 16;
  localparam int W_CNT   = 4;   // narrow counter so saturation is reachable
  localparam int CNT_MAX = (1 << W_CNT) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              v_i, use0_i, use1_i, wrsv_i;
  logic [ADDR-1:0]   pc_i;
  logic [W_IMM-1:0]  imm_i;
  logic [W_RD-1:0]   rs0_i, rs1_i, rd_i;
  logic [D_INFO-1:0] d_info_i;
  logic              stall_o, v_o, wrsv_o;
  logic [ADDR-1:0]   pc_o;
  logic [W_IMM-1:0]  imm_o;
  logic [W_OPR-1:0]  opr0_o, opr1_o;
  logic [D_INFO-1:0] d_info_o;
  logic [W_RD-1:0]   wb_r_o;
  logic              stall_i, branch_i, wb_i;
  logic [W_RD-1:0]   wb_r_i;
  logic [W_OPR-1:0]  wb_data_i;
  logic [W_CNT-1:0]  stall_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [W_OPR-1:0]  m_rf [32];
  bit                m_v;
  logic [ADDR-1:0]   m_pc;
  logic [W_IMM-1:0]  m_imm;
  logic [W_OPR-1:0]  m_opr0, m_opr1;
  logic [D_INFO-1:0] m_info;
  logic [W_RD-1:0]   m_wbr;
  bit                m_wrsv;
  int                m_cnt;

  reg_fetch #(
    .W_OPR(W_OPR), .W_RD(W_RD), .ADDR(ADDR), .W_IMM(W_IMM),
    .D_INFO(D_INFO), .W_CNT(W_CNT)
  ) dut (
    .clk(clk), .reset(reset),
    .v_i(v_i), .pc_i(pc_i), .imm_i(imm_i), .rs0_i(rs0_i), .rs1_i(rs1_i),
    .rd_i(rd_i), .use0_i(use0_i), .use1_i(use1_i), .wrsv_i(wrsv_i),
    .d_info_i(d_info_i), .stall_o(stall_o),
    .v_o(v_o), .pc_o(pc_o), .imm_o(imm_o), .opr0_o(opr0_o), .opr1_o(opr1_o),
    .d_info_o(d_info_o), .wb_r_o(wb_r_o), .wrsv_o(wrsv_o),
    .stall_i(stall_i), .branch_i(branch_i), .wb_i(wb_i), .wb_r_i(wb_r_i),
    .wb_data_i(wb_data_i), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_v = 0; m_pc = '0; m_imm = '0; m_opr0 = '0; m_opr1 = '0;
    m_info = '0; m_wbr = '0; m_wrsv = 0; m_cnt = 0;
  endtask

  function automatic logic [W_OPR-1:0] model_src(input logic [W_RD-1:0] r);
    return (wb_i && wb_r_i == r) ? wb_data_i : m_rf[r];
  endfunction

  function automatic bit model_hazard();
    bit reads_dest;
    reads_dest = (use0_i && rs0_i == m_wbr) || (use1_i && rs1_i == m_wbr);
    return v_i && m_v && m_wrsv && !branch_i && reads_dest;
  endfunction

  function automatic bit model_stall();
    return (m_v && stall_i) || model_hazard();
  endfunction

  // Advance DUT and model by one clock; returns at the following negedge.
  task automatic advance();
    bit hd, hz;
    logic [W_OPR-1:0] o0, o1;
    hd = m_v && stall_i;
    hz = model_hazard();
    o0 = use0_i ? model_src(rs0_i) : {27'b0, rs0_i};
    o1 = use1_i ? model_src(rs1_i) : '0;
    @(posedge clk);
    if (wb_i) m_rf[wb_r_i] = wb_data_i;
    if (!hd) begin
      if (hz) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (branch_i || hz) m_v = 0;
      else begin
        m_v = v_i; m_pc = pc_i; m_imm = imm_i; m_opr0 = o0; m_opr1 = o1;
        m_info = d_info_i; m_wbr = rd_i; m_wrsv = wrsv_i;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    v_i = 0; pc_i = '0; imm_i = '0; rs0_i = '0; rs1_i = '0; rd_i = '0;
    use0_i = 0; use1_i = 0; wrsv_i = 0; d_info_i = '0;
    stall_i = 0; branch_i = 0; wb_i = 0; wb_r_i = '0; wb_data_i = '0;
  endtask

  task automatic instr(input logic [ADDR-1:0] pc, input bit u0, input logic [W_RD-1:0] r0,
                       input bit u1, input logic [W_RD-1:0] r1,
                       input bit wr, input logic [W_RD-1:0] rd);
    v_i = 1; pc_i = pc; imm_i = pc ^ 16'h5A5A; d_info_i = ~pc;
    use0_i = u0; rs0_i = r0; use1_i = u1; rs1_i = r1; wrsv_i = wr; rd_i = rd;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({v_o, wrsv_o, stall_o} !== 3'b000)
      begin n_fail++; $display("FAIL reset_flags: got %b want 000", {v_o, wrsv_o, stall_o}); end
    n_tests++;
    if ({pc_o, imm_o, opr0_o, opr1_o, d_info_o, wb_r_o} !== '0)
      begin n_fail++; $display("FAIL reset_payload: got pc=%h imm=%h o0=%h o1=%h info=%h wbr=%h want all 0",
                               pc_o, imm_o, opr0_o, opr1_o, d_info_o, wb_r_o); end
    n_tests++;
    if (stall_cnt_o !== '0)
      begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt_o); end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_write_through();
    idle();
    instr(16'h0100, 1, 5'd3, 0, 5'd0, 0, 5'd7);
    wb_i = 1; wb_r_i = 5'd3; wb_data_i = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL wt_stall: got %b want 0", stall_o); end
    advance();
    n_tests++;
    if (v_o !== 1'b1 || opr0_o !== 32'hDEAD_BEEF || opr1_o !== '0)
      begin n_fail++; $display("FAIL wt_bypass: got v=%b o0=%h o1=%h want v=1 o0=deadbeef o1=0", v_o, opr0_o, opr1_o); end
    n_tests++;
    if (pc_o !== 16'h0100 || imm_o !== 16'h5B5A || d_info_o !== 16'hFEFF || wb_r_o !== 5'd7 || wrsv_o !== 1'b0)
      begin n_fail++; $display("FAIL wt_fields: got pc=%h imm=%h info=%h wbr=%0d wr=%b want 0100 5b5a feff 7 0",
                               pc_o, imm_o, d_info_o, wb_r_o, wrsv_o); end
    // register file now holds the value with no bypass active
    wb_i = 0;
    instr(16'h0104, 1, 5'd3, 0, 5'd0, 0, 5'd7);
    advance();
    n_tests++;
    if (opr0_o !== 32'hDEAD_BEEF)
      begin n_fail++; $display("FAIL wt_readback: got %h want deadbeef", opr0_o); end
    idle();
    advance();
  endtask

  task automatic test_raw_hazard();
    idle();
    instr(16'h0200, 0, 5'd0, 0, 5'd0, 1, 5'd5);       // A writes r5
    advance();
    n_tests++;
    if (v_o !== 1'b1 || wb_r_o !== 5'd5 || wrsv_o !== 1'b1)
      begin n_fail++; $display("FAIL raw_a_issue: got v=%b wbr=%0d wr=%b want 1 5 1", v_o, wb_r_o, wrsv_o); end
    instr(16'h0204, 0, 5'd2, 1, 5'd5, 0, 5'd6);       // B reads r5
    #1;
    n_tests++;
    if (stall_o !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b want 1", stall_o); end
    advance();
    n_tests++;
    if (v_o !== 1'b0 || stall_cnt_o !== 4'd1)
      begin n_fail++; $display("FAIL raw_bubble: got v=%b cnt=%0d want v=0 cnt=1", v_o, stall_cnt_o); end
    wb_i = 1; wb_r_i = 5'd5; wb_data_i = 32'h0000_0012;  // A's result arrives
    #1;
    n_tests++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL raw_release: got %b want 0", stall_o); end
    advance();
    n_tests++;
    if (v_o !== 1'b1 || opr1_o !== 32'h12 || opr0_o !== 32'h2 || pc_o !== 16'h0204 || stall_cnt_o !== 4'd1)
      begin n_fail++; $display("FAIL raw_b_issue: got v=%b o1=%h o0=%h pc=%h cnt=%0d want 1 12 2 0204 1",
                               v_o, opr1_o, opr0_o, pc_o, stall_cnt_o); end
    idle();
  endtask

  task automatic test_back_pressure();
    idle();
    instr(16'h0300, 1, 5'd3, 1, 5'd5, 1, 5'd9);       // C: r3, r5 -> r9
    advance();
    instr(16'h0304, 1, 5'd9, 0, 5'd0, 1, 5'd4);       // D reads r9 (hazard masked by hold)
    stall_i = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (stall_o !== 1'b1) begin n_fail++; $display("FAIL bp_stall[%0d]: got %b want 1", k, stall_o); end
      advance();
      n_tests++;
      if (v_o !== 1'b1 || pc_o !== 16'h0300 || opr0_o !== 32'hDEAD_BEEF || opr1_o !== 32'h12 ||
          wb_r_o !== 5'd9 || wrsv_o !== 1'b1 || stall_cnt_o !== 4'd1)
        begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h o0=%h o1=%h wbr=%0d wr=%b cnt=%0d want 1 0300 deadbeef 12 9 1 1",
                                 k, v_o, pc_o, opr0_o, opr1_o, wb_r_o, wrsv_o, stall_cnt_o); end
    end
    stall_i = 0;                                       // release: now D hazards on C
    #1;
    n_tests++;
    if (stall_o !== 1'b1) begin n_fail++; $display("FAIL bp_hazard: got %b want 1", stall_o); end
    advance();
    n_tests++;
    if (v_o !== 1'b0 || stall_cnt_o !== 4'd2)
      begin n_fail++; $display("FAIL bp_bubble: got v=%b cnt=%0d want 0 2", v_o, stall_cnt_o); end
    wb_i = 1; wb_r_i = 5'd9; wb_data_i = 32'h0000_0099;
    advance();
    n_tests++;
    if (v_o !== 1'b1 || opr0_o !== 32'h99 || pc_o !== 16'h0304)
      begin n_fail++; $display("FAIL bp_resume: got v=%b o0=%h pc=%h want 1 99 0304", v_o, opr0_o, pc_o); end
    wb_i = 0;
  endtask

  task automatic test_branch_squash();
    instr(16'h0400, 1, 5'd4, 0, 5'd0, 0, 5'd1);       // would hazard on D's r4
    branch_i = 1;
    #1;
    n_tests++;
    if (stall_o !== 1'b0) begin n_fail++; $display("FAIL br_stall: got %b want 0", stall_o); end
    advance();
    n_tests++;
    if (v_o !== 1'b0 || stall_cnt_o !== 4'd2)
      begin n_fail++; $display("FAIL br_squash: got v=%b cnt=%0d want 0 2", v_o, stall_cnt_o); end
    idle();
  endtask

  task automatic test_non_reg_operand();
    idle();
    instr(16'h0500, 0, 5'h0B, 0, 5'd3, 0, 5'd0);
    advance();
    n_tests++;
    if (v_o !== 1'b1 || opr0_o !== 32'h0000_000B || opr1_o !== '0)
      begin n_fail++; $display("FAIL nonreg: got v=%b o0=%h o1=%h want 1 0000000b 0", v_o, opr0_o, opr1_o); end
    idle();
    advance();
  endtask

  task automatic test_counter_saturation();
    // each instruction reads and writes r1, so every one bubbles once behind its predecessor
    idle();
    for (int k = 0; k < 40; k++) begin
      instr(16'h0600 + 16'(k), 1, 5'd1, 0, 5'd0, 1, 5'd1);
      advance();
      n_tests++;
      if (stall_cnt_o !== W_CNT'(m_cnt))
        begin n_fail++; $display("FAIL sat_step[%0d]: got %0d want %0d", k, stall_cnt_o, m_cnt); end
    end
    n_tests++;
    if (stall_cnt_o !== 4'hF) begin n_fail++; $display("FAIL sat_final: got %0d want 15", stall_cnt_o); end
    idle();
    advance();
  endtask

  task automatic test_random();
    bit keep = 0;
    idle();
    for (int c = 0; c < 600; c++) begin
      if (!keep) begin
        v_i = ($urandom_range(0, 3) != 0);
        pc_i = 16'($urandom); imm_i = 16'($urandom); d_info_i = 16'($urandom);
        rs0_i = 5'($urandom_range(0, 3)); rs1_i = 5'($urandom_range(0, 3));
        rd_i = 5'($urandom_range(0, 3));
        use0_i = $urandom_range(0, 1); use1_i = $urandom_range(0, 1); wrsv_i = $urandom_range(0, 1);
      end
      stall_i   = ($urandom_range(0, 4) == 0);
      branch_i  = m_v && ($urandom_range(0, 6) == 0);
      wb_i      = $urandom_range(0, 1);
      wb_r_i    = 5'($urandom_range(0, 7));
      wb_data_i = $urandom;
      #1;
      keep = model_stall();
      n_tests++;
      if (stall_o !== keep) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %b want %b", c, stall_o, keep); end
      keep = keep && !branch_i;
      advance();
      n_tests++;
      if (v_o !== m_v || stall_cnt_o !== W_CNT'(m_cnt))
        begin n_fail++; $display("FAIL rnd_ctl[%0d]: got v=%b cnt=%0d want v=%b cnt=%0d", c, v_o, stall_cnt_o, m_v, m_cnt); end
      if (m_v) begin
        n_tests++;
        if (pc_o !== m_pc || imm_o !== m_imm || opr0_o !== m_opr0 || opr1_o !== m_opr1 ||
            d_info_o !== m_info || wb_r_o !== m_wbr || wrsv_o !== m_wrsv)
          begin n_fail++; $display("FAIL rnd_data[%0d]: got pc=%h imm=%h o0=%h o1=%h info=%h wbr=%0d wr=%b want %h %h %h %h %h %0d %b",
                                   c, pc_o, imm_o, opr0_o, opr1_o, d_info_o, wb_r_o, wrsv_o,
                                   m_pc, m_imm, m_opr0, m_opr1, m_info, m_wbr, m_wrsv); end
      end
    end
    idle();
    advance();
  endtask

  task automatic test_reset_mid_run();
    idle();
    instr(16'h0700, 1, 5'd3, 1, 5'd5, 1, 5'd2);
    advance();
    n_tests++;
    if (v_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got v=%b want 1", v_o); end
    #2 reset = 1;                                      // asynchronous, away from any edge
    #1;
    model_reset();
    n_tests++;
    if ({v_o, wrsv_o, stall_o, pc_o, imm_o, opr0_o, opr1_o, d_info_o, wb_r_o, stall_cnt_o} !== '0)
      begin n_fail++; $display("FAIL mid_async: got v=%b pc=%h o0=%h o1=%h cnt=%0d want all 0",
                               v_o, pc_o, opr0_o, opr1_o, stall_cnt_o); end
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    idle();
    for (int k = 0; k < 16; k++) begin
      instr(16'h0800 + 16'(k), 1, 5'(2 * k), 1, 5'(2 * k + 1), 0, 5'd0);
      advance();
      n_tests++;
      if (v_o !== 1'b1 || opr0_o !== '0 || opr1_o !== '0)
        begin n_fail++; $display("FAIL mid_rf[%0d]: got v=%b o0=%h o1=%h want 1 0 0", k, v_o, opr0_o, opr1_o); end
    end
    idle();
    advance();
  endtask

  initial begin
    test_reset();
    test_write_through();
    test_raw_hazard();
    test_back_pressure();
    test_branch_squash();
    test_non_reg_operand();
    test_counter_saturation();
    test_random();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_fetch.md
Name: reg_fetch

Overview:
- Operand-fetch stage that sits directly upstream of the execute stage.
- Holds the 32-entry general register file and takes the decoded instruction stream from decode.
- Reads two source operands, with write-through bypass from the execute stage's writeback port.
- Detects read-after-write hazards against the instruction it is handing to execute and inserts bubbles; honours execute back-pressure and squashes the wrong-path instruction on a taken branch.

Parameters:
- W_OPR, 32, operand/register width
- W_RD, 5, register index width (2**W_RD registers)
- ADDR, 16, program counter width
- W_IMM, 16, immediate width
- D_INFO, 16, decode-info bundle width (passed through untouched)
- W_CNT, 16, stall counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- v_i  in  1  decode instruction valid
- pc_i  in  ADDR  instruction pc
- imm_i  in  W_IMM  immediate
- rs0_i  in  W_RD  source 0 index (or condition code when use0_i=0)
- rs1_i  in  W_RD  source 1 index
- rd_i  in  W_RD  destination index
- use0_i  in  1  source 0 is a register read
- use1_i  in  1  source 1 is a register read
- wrsv_i  in  1  instruction writes rd
- d_info_i  in  D_INFO  decode info
- stall_o  out  1  hold decode (do not advance)
- v_o  out  1  valid to execute
- pc_o  out  ADDR  registered pc
- imm_o  out  W_IMM  registered immediate
- opr0_o  out  W_OPR  operand 0
- opr1_o  out  W_OPR  operand 1
- d_info_o  out  D_INFO  registered decode info
- wb_r_o  out  W_RD  registered destination
- wrsv_o  out  1  registered write flag
- stall_i  in  1  execute back-pressure
- branch_i  in  1  execute reports taken branch for the instruction at v_o
- wb_i  in  1  writeback enable from execute
- wb_r_i  in  W_RD  writeback register
- wb_data_i  in  W_OPR  writeback data
- stall_cnt_o  out  W_CNT  saturating count of hazard-bubble cycles

Behaviour:
- Reset (async, active-high):
  - all outputs and pipeline registers go to 0; v_o=0; all 2**W_RD registers = 0; stall_cnt_o=0.
  - Reset mid-operation discards the in-flight instruction.
- Register file:
  - Written on posedge clk when wb_i=1: rf[wb_r_i] <= wb_data_i.
  - All registers are general purpose; there is no hardwired zero.
- Operand read (combinational from the input instruction):
  - src = (wb_i & wb_r_i==rs) ? wb_data_i : rf[rs].
  - opr0 = use0_i ? src(rs0_i) : zero-extended rs0_i. This carries the branch condition code in the low bits.
  - opr1 = use1_i ? src(rs1_i) : 0.
- hold = v_o & stall_i. While hold, every output register keeps its value.
- hazard = v_i & v_o & wrsv_o & ~branch_i & ((use0_i & rs0_i==wb_r_o) | (use1_i & rs1_i==wb_r_o)).
- stall_o = hold | hazard.
- When ~hold, output registers update each posedge clk:
  - branch_i=1: v_o<=0. The input instruction is discarded and decode is not stalled; upstream refetches.
  - hazard=1: v_o<=0 (bubble), other fields don't-care. The input instruction is retained by decode via stall_o. Next cycle the producer's result arrives on wb_*, is bypassed, and the instruction issues.
  - otherwise: v_o<=v_i; pc/imm/d_info/wb_r/wrsv/opr0/opr1 <= input values.
- Load latency: no extra cycles beyond the 1-bubble rule, because the execute stage already merges load data onto wb_data_i.
- Operands captured in the output register are never refreshed while held. Their sources were resolved at capture time.
- Latency: 1 cycle from v_i (no hazard, no hold) to v_o.
- stall_cnt_o increments by 1 on each posedge where hazard & ~hold. It saturates at all-ones.
- Simultaneous hold and hazard: hold wins (outputs held, count unchanged).
- Simultaneous branch_i and stall_i: hold wins; the branch is re-presented by execute.

Test Plan:
- Write-through: wb_i=1, wb_r_i=3, wb_data_i=0xDEAD_BEEF in the same cycle as v_i with use0_i=1, rs0_i=3 -> next cycle v_o=1, opr0_o=0xDEADBEEF; rf[3] reads 0xDEADBEEF afterwards.
- RAW hazard: issue A (rd=5, wrsv=1) then B (rs1=5) -> B sees stall_o=1 for one cycle, one v_o=0 bubble, stall_cnt_o=1. B then issues with opr1_o equal to A's wb_data_i (e.g. 0x12).
- Back-pressure: v_o=1 and stall_i=1 held for 3 cycles -> all outputs constant, stall_o=1 for those 3 cycles, stall_cnt_o unchanged. Resume on release.
- Branch squash: v_o=1, branch_i=1, v_i=1 -> next cycle v_o=0, stall_o=0 during the branch cycle, no hazard counted.
- Non-register operand: use0_i=0, rs0_i=0x0B -> opr0_o=0x0000_000B regardless of rf.
- Reset mid-run: assert reset with v_o=1 and rf populated -> v_o=0, all outputs 0, every register reads 0, stall_cnt_o=0 immediately (asynchronously).
